// File: rtl/spio_link_speed_halver.sv
`default_nettype none
// ============================================================================
// Module   : spio_link_speed_halver
// Purpose  : Carries a valid/ready packet stream from the fast link clock
//            (fclk_i, exactly 2x sclk_i, rising edges phase-aligned) back to
//            the system clock. A small FIFO in the fclk domain absorbs bursts;
//            the sclk side drains one packet per sclk cycle into a registered
//            output stage.
// Ports    : sclk_i      system clock (output stream timing)
//            reset_i     asynchronous active-low reset, both domains
//            fclk_i      fast clock, rising edges coincide with sclk_i edges
//            in_data_i   input packet            (fclk domain)
//            in_vld_i    input valid             (fclk domain)
//            in_rdy_o    input ready, registered (fclk domain)
//            out_data_o  output packet, registered (sclk domain)
//            out_vld_o   output valid, registered  (sclk domain)
//            out_rdy_i   output ready              (sclk domain)
// Revision : 1.0 - initial release
// ============================================================================
module spio_link_speed_halver #(
  parameter int PKT_BITS  = 72,
  parameter int BUF_DEPTH = 4    // power of 2, >= 2
) (
  input  logic                sclk_i,
  input  logic                reset_i,
  input  logic                fclk_i,
  input  logic [PKT_BITS-1:0] in_data_i,
  input  logic                in_vld_i,
  output logic                in_rdy_o,
  output logic [PKT_BITS-1:0] out_data_o,
  output logic                out_vld_o,
  input  logic                out_rdy_i
);

  localparam int                c_AW      = $clog2(BUF_DEPTH);
  localparam logic [c_AW:0]     c_DEPTH   = (c_AW+1)'(BUF_DEPTH);
  localparam logic [c_AW:0]     c_CNT_ONE = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]   c_PTR_ONE = c_AW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // fclk domain
  logic [PKT_BITS-1:0] mem_q [BUF_DEPTH];
  logic [c_AW-1:0]     wr_ptr_q;
  logic [c_AW-1:0]     rd_ptr_q;
  logic [c_AW:0]       count_q;
  logic [c_AW:0]       count_d;
  logic                in_rdy_q;
  logic                in_rdy_d;
  logic                f_tog_q;
  // sclk domain
  logic                s_tog_q;
  logic [PKT_BITS-1:0] out_data_q;
  logic                out_vld_q;

  logic                w_aligned;
  logic                w_load;
  logic                w_nonempty;
  logic                w_push;
  logic                w_pop;

  // --------------------------------------------------------------------------
  // Phase detection: s_tog flips every sclk edge and f_tog copies it every
  // fclk edge, so the two agree just before an fclk edge only when that edge
  // is also an sclk edge. On the very first edge after reset both are 0 and
  // the edge may be misclassified; the FIFO is empty then, so no pop results.
  // --------------------------------------------------------------------------
  assign w_aligned  = (s_tog_q == f_tog_q);

  // Output stage may take a new packet when empty or being consumed. Both
  // domains evaluate this from the same pre-edge values on aligned edges,
  // which keeps each sclk load paired with exactly one fclk pop.
  assign w_load     = !out_vld_q || out_rdy_i;
  assign w_nonempty = (count_q != '0);
  assign w_push     = in_vld_i && in_rdy_q;
  assign w_pop      = w_aligned && w_load && w_nonempty;

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_ONE;
    end else if (!w_push && w_pop) begin
      count_d = count_q - c_CNT_ONE;
    end
    // Ready is a function of the post-update count only, keeping out_rdy_i
    // off any combinational path to in_rdy_o.
    in_rdy_d = (count_d < c_DEPTH);
  end

  // --------------------------------------------------------------------------
  // fclk domain: pointers, occupancy, ready, storage
  // --------------------------------------------------------------------------
  always_ff @(posedge fclk_i or negedge reset_i) begin
    if (!reset_i) begin
      f_tog_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_rdy_q <= 1'b0;
    end else begin
      f_tog_q  <= s_tog_q;
      count_q  <= count_d;
      in_rdy_q <= in_rdy_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      end
    end
  end

  always_ff @(posedge fclk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // sclk domain: output register. Head and count are fclk registers that are
  // stable across the aligned edge, so they are read here directly.
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk_i or negedge reset_i) begin
    if (!reset_i) begin
      s_tog_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      s_tog_q <= !s_tog_q;
      if (w_load) begin
        out_vld_q <= w_nonempty;
        if (w_nonempty) begin
          out_data_q <= mem_q[rd_ptr_q];
        end
      end
    end
  end

  assign in_rdy_o   = in_rdy_q;
  assign out_vld_o  = out_vld_q;
  assign out_data_o = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spio_link_speed_halver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spio_link_speed_halver
// Purpose  : Self-checking bench. Every packet accepted on the fast side is
//            queued in order; every packet handshaken on the slow side must
//            match the queue head. Directed scenarios add timing checks for
//            capacity, latency, ready alternation and reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spio_link_speed_halver;

  localparam int PKT_BITS  = 72;
  localparam int BUF_DEPTH = 4;

  logic                sclk;
  logic                fclk;
  logic                reset_n;
  logic [PKT_BITS-1:0] in_data;
  logic                in_vld;
  logic                in_rdy;
  logic [PKT_BITS-1:0] out_data;
  logic                out_vld;
  logic                out_rdy;

  spio_link_speed_halver #(
    .PKT_BITS  (PKT_BITS),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .sclk_i     (sclk),
    .reset_i    (reset_n),
    .fclk_i     (fclk),
    .in_data_i  (in_data),
    .in_vld_i   (in_vld),
    .in_rdy_o   (in_rdy),
    .out_data_o (out_data),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy)
  );

  // Both clocks from one process: sclk toggles on every fclk rise, so its
  // rising edges land on every other fclk rising edge in the same timestep.
  initial begin
    fclk = 1'b0;
    sclk = 1'b0;
    forever begin
      #5 fclk = 1'b1;
      sclk = ~sclk;
      #5 fclk = 1'b0;
    end
  end

  int                  n_checks = 0;
  int                  n_fail   = 0;
  logic [PKT_BITS-1:0] acc_q[$];      // accepted on the fast side, in order
  logic [PKT_BITS-1:0] out_q[$];      // handshaken on the slow side, in order
  logic [PKT_BITS-1:0] drv_data;
  bit                  rand_data;
  logic                smp_in_rdy;
  logic                smp_out_vld;
  logic                smp_pre_al;    // next fclk edge is an sclk edge

  function automatic logic [PKT_BITS-1:0] rand_pkt();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PKT_BITS-1:0];
  endfunction

  // One fclk cycle: drive at edge+1, observe mid-cycle, advance past the edge.
  task automatic step(input logic vld, input logic rdy);
    logic took;
    in_vld  = vld;
    in_data = drv_data;
    out_rdy = rdy;
    @(negedge fclk);
    took        = vld && in_rdy;
    smp_in_rdy  = in_rdy;
    smp_out_vld = out_vld;
    smp_pre_al  = !sclk;
    if (took) acc_q.push_back(drv_data);
    if (!sclk && out_vld && out_rdy) out_q.push_back(out_data);
    @(posedge fclk);
    #1;
    if (took) drv_data = rand_data ? rand_pkt() : drv_data + 1'b1;
  endtask

  // phase 0: release right after an sclk edge; phase 1: right after a
  // non-aligned fclk edge.
  task automatic do_reset(input bit phase);
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge fclk);
    do begin
      @(posedge fclk);
      #1;
    end while (sclk != (phase == 1'b0));
    reset_n = 1'b1;
    acc_q.delete();
    out_q.delete();
  endtask

  task automatic test_reset();
    in_vld   = 1'b0;
    out_rdy  = 1'b0;
    drv_data = '0;
    in_data  = '0;
    reset_n  = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b required 0", in_rdy); end
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b required 0", out_vld); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    do_reset(1'b1);
    step(1'b0, 1'b0);
    n_checks++;
    if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_rdy: got %b required 1", in_rdy); end
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_vld: got %b required 0", out_vld); end
  endtask

  task automatic test_full_throughput();
    int gaps, alt_err, win_acc;
    logic prev_rdy;
    logic [PKT_BITS-1:0] got, exp;
    do_reset(1'b0);
    gaps = 0; alt_err = 0; win_acc = 0; prev_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1);
      if (i >= 10 && smp_pre_al && !smp_out_vld) gaps++;
      if (i >= 12) begin
        if (smp_in_rdy == prev_rdy) alt_err++;
        if (smp_in_rdy) win_acc++;
      end
      prev_rdy = smp_in_rdy;
    end
    n_checks++;
    if (gaps != 0) begin n_fail++; $display("FAIL tput_vld_gaps: got %0d required 0", gaps); end
    n_checks++;
    if (alt_err != 0) begin n_fail++; $display("FAIL tput_rdy_alternate: got %0d repeats required 0", alt_err); end
    n_checks++;
    if (win_acc != 14) begin n_fail++; $display("FAIL tput_accept_rate: got %0d of 28 required 14", win_acc); end
    repeat (24) step(1'b0, 1'b1);
    n_checks++;
    if (out_q.size() != acc_q.size()) begin n_fail++; $display("FAIL tput_count: got %0d required %0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      got = out_q.pop_front(); exp = acc_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL tput_order: got %h required %h", got, exp); end
    end
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_block_output();
    logic [PKT_BITS-1:0] held, got, exp;
    int wait_n;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      if (i == 10) held = out_data;
    end
    n_checks++;
    if (acc_q.size() != BUF_DEPTH + 1) begin n_fail++; $display("FAIL block_capacity: got %0d required %0d", acc_q.size(), BUF_DEPTH + 1); end
    n_checks++;
    if (smp_in_rdy !== 1'b0) begin n_fail++; $display("FAIL block_in_rdy: got %b required 0", smp_in_rdy); end
    n_checks++;
    if (out_data !== held) begin n_fail++; $display("FAIL block_data_stable: got %h required %h", out_data, held); end
    n_checks++;
    if (acc_q.size() > 0 && out_data !== acc_q[0]) begin n_fail++; $display("FAIL block_head: got %h required %h", out_data, acc_q[0]); end
    wait_n = 0;
    do begin
      step(1'b1, 1'b1);
      wait_n++;
    end while (!smp_in_rdy && wait_n < 6);
    n_checks++;
    if (wait_n > 3) begin n_fail++; $display("FAIL unblock_latency: got %0d cycles required <= 3", wait_n); end
    repeat (20) step(1'b1, 1'b1);
    repeat (24) step(1'b0, 1'b1);
    n_checks++;
    if (out_q.size() != acc_q.size()) begin n_fail++; $display("FAIL block_count: got %0d required %0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      got = out_q.pop_front(); exp = acc_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL block_order: got %h required %h", got, exp); end
    end
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_idle_restart();
    logic [PKT_BITS-1:0] last_out, got, exp;
    repeat (10) step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL idle_out_vld: got %b required 0", out_vld); end
    last_out = (out_q.size() > 0) ? out_q[$] : '0;
    n_checks++;
    if (out_q.size() != acc_q.size()) begin n_fail++; $display("FAIL idle_count: got %0d required %0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      got = out_q.pop_front(); exp = acc_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL idle_order: got %h required %h", got, exp); end
    end
    acc_q.delete(); out_q.delete();
    repeat (10) step(1'b1, 1'b1);
    repeat (24) step(1'b0, 1'b1);
    exp = last_out + 1'b1;
    n_checks++;
    if (out_q.size() == 0 || out_q[0] !== exp) begin
      n_fail++;
      $display("FAIL restart_first: got %h required %h", (out_q.size() > 0) ? out_q[0] : '0, exp);
    end
    n_checks++;
    if (out_q.size() != acc_q.size()) begin n_fail++; $display("FAIL restart_count: got %0d required %0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      got = out_q.pop_front(); exp = acc_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL restart_order: got %h required %h", got, exp); end
    end
    acc_q.delete(); out_q.delete();
  endtask

  // Single packet into an empty pipe: pushed on an sclk edge it waits a full
  // sclk period (2 fclk), pushed between sclk edges it appears 1 fclk later.
  task automatic test_latency();
    int lat;
    logic [PKT_BITS-1:0] pushed;
    for (int ph = 0; ph < 2; ph++) begin
      for (int g = 0; g < 3; g++) begin
        if (sclk == (ph == 1)) break;
        step(1'b0, 1'b1);
      end
      pushed = drv_data;
      step(1'b1, 1'b1);
      lat = 0;
      while (!out_vld && lat < 6) begin
        step(1'b0, 1'b1);
        lat++;
      end
      n_checks++;
      if (lat != ((ph == 0) ? 2 : 1)) begin n_fail++; $display("FAIL latency_ph%0d: got %0d required %0d", ph, lat, (ph == 0) ? 2 : 1); end
      n_checks++;
      if (out_data !== pushed) begin n_fail++; $display("FAIL latency_data_ph%0d: got %h required %h", ph, out_data, pushed); end
      repeat (8) step(1'b0, 1'b1);
      acc_q.delete(); out_q.delete();
    end
  endtask

  // Random valid/ready toggled on every fclk edge, aligned or not, with
  // periodic stretches of blocked output and random packet contents.
  task automatic test_mid_sclk_unblock();
    logic [PKT_BITS-1:0] got, exp;
    logic rdy;
    rand_data = 1'b1;
    drv_data  = rand_pkt();
    for (int i = 0; i < 300; i++) begin
      rdy = ((i % 40) < 10) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step(($urandom_range(0, 3) != 0), rdy);
    end
    repeat (24) step(1'b0, 1'b1);
    rand_data = 1'b0;
    drv_data  = 72'h100;
    n_checks++;
    if (out_q.size() != acc_q.size()) begin n_fail++; $display("FAIL random_count: got %0d required %0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      got = out_q.pop_front(); exp = acc_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL random_order: got %h required %h", got, exp); end
    end
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    logic [PKT_BITS-1:0] first, got, exp;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    in_vld = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL midreset_out_vld: got %b required 0", out_vld); end
    n_checks++;
    if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL midreset_in_rdy: got %b required 0", in_rdy); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL midreset_out_data: got %h required 0", out_data); end
    do_reset(1'b0);
    first = drv_data;
    repeat (12) step(1'b1, 1'b1);
    repeat (24) step(1'b0, 1'b1);
    n_checks++;
    if (out_q.size() == 0 || out_q[0] !== first) begin
      n_fail++;
      $display("FAIL midreset_first: got %h required %h", (out_q.size() > 0) ? out_q[0] : '0, first);
    end
    n_checks++;
    if (out_q.size() != acc_q.size()) begin n_fail++; $display("FAIL midreset_count: got %0d required %0d", out_q.size(), acc_q.size()); end
    while (out_q.size() > 0 && acc_q.size() > 0) begin
      got = out_q.pop_front(); exp = acc_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL midreset_order: got %h required %h", got, exp); end
    end
    acc_q.delete(); out_q.delete();
  endtask

  task automatic test_reset_phase();
    logic [PKT_BITS-1:0] got, exp;
    for (int ph = 0; ph < 2; ph++) begin
      do_reset(ph[0]);
      for (int i = 0; i < 40; i++) begin
        step(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0));
      end
      repeat (24) step(1'b0, 1'b1);
      n_checks++;
      if (out_q.size() != acc_q.size()) begin n_fail++; $display("FAIL phase%0d_count: got %0d required %0d", ph, out_q.size(), acc_q.size()); end
      while (out_q.size() > 0 && acc_q.size() > 0) begin
        got = out_q.pop_front(); exp = acc_q.pop_front();
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL phase%0d_order: got %h required %h", ph, got, exp); end
      end
      acc_q.delete(); out_q.delete();
    end
  endtask

  initial begin
    rand_data = 1'b0;
    test_reset();
    test_full_throughput();
    test_block_output();
    test_idle_restart();
    test_latency();
    test_mid_sclk_unblock();
    test_reset_mid_burst();
    test_reset_phase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
